// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - control-unit <-> datapath/memory signal bundle
interface main_control_fsm_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_req;
  logic             mem_we;
  logic             i_or_d;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic             fault;

  // Controller side
  modport master (
    input  start, opcode, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src,
           ir_write, mem_req, mem_we, i_or_d, reg_write, reg_dst, mem_to_reg,
           retired, halted, fault
  );

  // Datapath / memory side
  modport slave (
    output start, opcode, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src,
           ir_write, mem_req, mem_we, i_or_d, reg_write, reg_dst, mem_to_reg,
           retired, halted, fault
  );
endinterface

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle main control FSM for the 16-bit processor
module main_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic                clk,
  input logic                rst_n,
  main_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    st_idle, st_fetch, st_decode, st_exec_r, st_wb_r, st_exec_i, st_wb_i,
    st_mem_addr, st_mem_acc, st_wb_mem, st_branch, st_jump, st_halt, st_fault
  } state_t;

  // Registered Moore controls; pc_write here only covers the jump load
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       halted;
    logic       fault;
  } ctl_t;

  localparam logic [7:0] wait_last = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  ctl_t             ctl_q;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire, in_mem, timeout, fetch_done;

  // Control word for a state; opcode is stable from DECODE onward
  function automatic ctl_t decode(input state_t s, input logic [3:0] op);
    ctl_t c;
    c = '0;
    case (s)
      st_fetch: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'd1;
      end
      st_decode:   c.alu_src_b = 2'd3;
      st_exec_r: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd2;
      end
      st_wb_r: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'd1;
      end
      st_exec_i: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = (op == 4'h6) ? 2'd3 : 2'd0;
      end
      st_wb_i:     c.reg_write = 1'b1;
      st_mem_addr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      st_mem_acc: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
        c.mem_we  = (op == 4'h3);
      end
      st_wb_mem: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'd1;
      end
      st_branch: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd1;
        c.pc_src    = 2'd1;
      end
      st_jump: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'd2;
        if (op == 4'h8) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = 2'd2;
          c.mem_to_reg = 2'd2;
        end
      end
      st_halt:     c.halted = 1'b1;
      st_fault:    c.fault  = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  // Next state, retirement and memory-timeout detection
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    in_mem  = (state_q == st_fetch) || (state_q == st_mem_acc);
    timeout = in_mem && !bus.mem_ready && (wait_q == wait_last);
    case (state_q)
      st_idle:     if (bus.start) state_d = st_fetch;
      st_fetch: begin
        if (bus.mem_ready)  state_d = st_decode;
        else if (timeout)   state_d = st_fault;
      end
      st_decode: begin
        case (bus.opcode)
          4'h0:       state_d = st_exec_r;
          4'h1, 4'h6: state_d = st_exec_i;
          4'h2, 4'h3: state_d = st_mem_addr;
          4'h4, 4'h5: state_d = st_branch;
          4'h7, 4'h8: state_d = st_jump;
          4'hf:       state_d = st_halt;
          default:    state_d = st_fault;
        endcase
      end
      st_exec_r:   state_d = st_wb_r;
      st_exec_i:   state_d = st_wb_i;
      st_mem_addr: state_d = st_mem_acc;
      st_mem_acc: begin
        if (bus.mem_ready) begin
          if (bus.opcode == 4'h3) begin
            state_d = st_fetch;
            retire  = 1'b1;
          end else begin
            state_d = st_wb_mem;
          end
        end else if (timeout) begin
          state_d = st_fault;
        end
      end
      st_wb_r, st_wb_i, st_wb_mem, st_branch, st_jump: begin
        state_d = st_fetch;
        retire  = 1'b1;
      end
      default:     state_d = state_q;
    endcase
  end

  // State, registered controls, wait counter and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= st_idle;
      ctl_q     <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode(state_d, bus.opcode);
      if (state_d != state_q)
        wait_q <= '0;
      else if (in_mem && !bus.mem_ready)
        wait_q <= wait_q + 8'd1;
      if (retire)
        retired_q <= retired_q + 1'b1;
    end
  end

  // Handshake-qualified strobes must react to mem_ready/zero in the same cycle
  assign fetch_done        = (state_q == st_fetch) && bus.mem_ready;
  assign bus.ir_write      = fetch_done;
  assign bus.pc_write      = ctl_q.pc_write || fetch_done;
  assign bus.pc_write_cond = (state_q == st_branch) &&
                             (bus.opcode[0] ? !bus.zero : bus.zero);

  assign bus.alu_op     = ctl_q.alu_op;
  assign bus.alu_src_a  = ctl_q.alu_src_a;
  assign bus.alu_src_b  = ctl_q.alu_src_b;
  assign bus.pc_src     = ctl_q.pc_src;
  assign bus.mem_req    = ctl_q.mem_req;
  assign bus.mem_we     = ctl_q.mem_we;
  assign bus.i_or_d     = ctl_q.i_or_d;
  assign bus.reg_write  = ctl_q.reg_write;
  assign bus.reg_dst    = ctl_q.reg_dst;
  assign bus.mem_to_reg = ctl_q.mem_to_reg;
  assign bus.halted     = ctl_q.halted;
  assign bus.fault      = ctl_q.fault;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - randomized self-checking bench for main_control_fsm
module tb_main_control_fsm;
  localparam int TMO = 15;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       halted;
    logic       fault;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         model_retired = 0;
  logic [3:0] cur_op = 4'h0;
  ctl_t       obs;
  ctl_t       zero_ctl = '0;

  main_control_fsm_if #(.CNT_W(16)) bus ();
  main_control_fsm_if #(.CNT_W(4))  bus4 ();

  main_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  main_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  assign obs = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.pc_write_cond,
                bus.pc_src, bus.ir_write, bus.mem_req, bus.mem_we, bus.i_or_d,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.halted, bus.fault};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs after the falling edge, then compare
  task automatic check_cyc(input logic mr, input logic z, input ctl_t exp, input string tag);
    @(negedge clk);
    bus.opcode    = cur_op;
    bus.mem_ready = mr;
    bus.zero      = z;
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ctl: observed %h expected %h", tag, obs, exp);
    end
    checks++;
    assert (bus.retired === 16'(model_retired)) else begin
      errors++;
      $error("FAIL %s retired: observed %0d expected %0d", tag, bus.retired, 16'(model_retired));
    end
  endtask

  // Memory access lasting n unanswered cycles; n >= TMO means it times out
  task automatic mem_phase(input ctl_t e_wait, input ctl_t e_done, input int n,
                           input string tag, output bit to);
    to = 1'b0;
    for (int i = 0; i < n && i < TMO; i++) check_cyc(1'b0, rb(), e_wait, tag);
    if (n >= TMO) to = 1'b1;
    else check_cyc(1'b1, rb(), e_done, tag);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction
  task automatic run_instr(input logic [3:0] op, input int fwait, input int mwait,
                           input logic z, output bit ended);
    ctl_t e, d;
    bit   to;
    ended  = 1'b0;
    cur_op = op;
    e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'd1;
    d = e;  d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_phase(e, d, fwait, "fetch", to);
    if (to) begin ended = 1'b1; return; end
    e = '0; e.alu_src_b = 2'd3;
    check_cyc(rb(), rb(), e, "decode");
    case (op)
      4'h0: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd2;
        check_cyc(rb(), rb(), e, "exec_r");
        e = '0; e.reg_write = 1'b1; e.reg_dst = 2'd1;
        check_cyc(rb(), rb(), e, "wb_r");
        model_retired++;
      end
      4'h1, 4'h6: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        e.alu_op = (op == 4'h6) ? 2'd3 : 2'd0;
        check_cyc(rb(), rb(), e, "exec_i");
        e = '0; e.reg_write = 1'b1;
        check_cyc(rb(), rb(), e, "wb_i");
        model_retired++;
      end
      4'h2, 4'h3: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        check_cyc(rb(), rb(), e, "mem_addr");
        e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (op == 4'h3);
        mem_phase(e, e, mwait, "mem_acc", to);
        if (to) begin ended = 1'b1; return; end
        if (op == 4'h3) begin
          model_retired++;
        end else begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'd1;
          check_cyc(rb(), rb(), e, "wb_mem");
          model_retired++;
        end
      end
      4'h4, 4'h5: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'd1;
        e.pc_write_cond = (op == 4'h4) ? z : !z;
        check_cyc(rb(), z, e, "branch");
        model_retired++;
      end
      4'h7, 4'h8: begin
        e = '0; e.pc_write = 1'b1; e.pc_src = 2'd2;
        if (op == 4'h8) begin
          e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
        end
        check_cyc(rb(), rb(), e, "jump");
        model_retired++;
      end
      default: ended = 1'b1;
    endcase
  endtask

  task automatic terminal(input int n, input bit is_halt, input string tag);
    ctl_t e;
    e = '0; e.halted = is_halt; e.fault = !is_halt;
    for (int i = 0; i < n; i++) check_cyc(rb(), rb(), e, tag);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_retired = 0;
    checks++;
    assert (obs === zero_ctl) else begin
      errors++;
      $error("FAIL reset ctl: observed %h expected %h", obs, zero_ctl);
    end
    checks++;
    assert (bus.retired === 16'd0) else begin
      errors++;
      $error("FAIL reset retired: observed %0d expected 0", bus.retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_end(input bit ended, input bit want, input string tag);
    checks++;
    assert (ended == want) else begin
      errors++;
      $error("FAIL %s terminal: observed %0d expected %0d", tag, ended, want);
    end
  endtask

  initial begin
    bit         ended;
    int         f, m, exp4;
    logic [3:0] op;
    ctl_t       e;
    bus.start  = 1'b0; bus.opcode  = 4'h0; bus.zero  = 1'b0; bus.mem_ready  = 1'b0;
    bus4.start = 1'b0; bus4.opcode = 4'h7; bus4.zero = 1'b0; bus4.mem_ready = 1'b1;

    do_reset();
    check_cyc(rb(), rb(), zero_ctl, "idle_no_start");
    check_cyc(rb(), rb(), zero_ctl, "idle_no_start");
    bus.start = 1'b1;

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 8));
      f  = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
      m  = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
      run_instr(op, f, m, rb(), ended);
      expect_end(ended, 1'b0, "random_program");
    end

    run_instr(4'h1, 0, 0, rb(), ended);     expect_end(ended, 1'b0, "addi");
    run_instr(4'h0, 0, 0, rb(), ended);     expect_end(ended, 1'b0, "rtype");
    run_instr(4'h2, 0, 3, rb(), ended);     expect_end(ended, 1'b0, "lw_delay3");
    run_instr(4'h3, 1, 2, rb(), ended);     expect_end(ended, 1'b0, "sw");
    run_instr(4'h4, 0, 0, 1'b1, ended);     expect_end(ended, 1'b0, "beq_z1");
    run_instr(4'h5, 0, 0, 1'b1, ended);     expect_end(ended, 1'b0, "bne_z1");
    run_instr(4'h4, 0, 0, 1'b0, ended);     expect_end(ended, 1'b0, "beq_z0");
    run_instr(4'h5, 0, 0, 1'b0, ended);     expect_end(ended, 1'b0, "bne_z0");
    run_instr(4'h6, 0, 0, rb(), ended);     expect_end(ended, 1'b0, "ori");
    run_instr(4'h8, 0, 0, rb(), ended);     expect_end(ended, 1'b0, "jal");
    run_instr(4'h1, TMO - 1, 0, 1'b0, ended); expect_end(ended, 1'b0, "fetch_ready_at_limit");
    run_instr(4'h2, 0, TMO - 1, 1'b0, ended); expect_end(ended, 1'b0, "mem_ready_at_limit");

    run_instr(4'hf, 0, 0, 1'b0, ended);     expect_end(ended, 1'b1, "halt");
    terminal(6, 1'b1, "halt_hold");
    do_reset();
    run_instr(4'ha, 0, 0, 1'b0, ended);     expect_end(ended, 1'b1, "illegal");
    terminal(6, 1'b0, "illegal_fault");
    do_reset();
    run_instr(4'h1, TMO, 0, 1'b0, ended);   expect_end(ended, 1'b1, "fetch_timeout");
    terminal(20, 1'b0, "fetch_timeout_hold");
    do_reset();
    run_instr(4'h3, 0, TMO, 1'b0, ended);   expect_end(ended, 1'b1, "mem_timeout");
    terminal(5, 1'b0, "mem_timeout_hold");
    do_reset();

    cur_op = 4'h2;
    e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'd1;
    check_cyc(1'b0, 1'b0, e, "pre_reset_fetch");
    check_cyc(1'b0, 1'b0, e, "pre_reset_fetch");
    do_reset();

    bus.start  = 1'b0;
    bus4.start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      #1;
      exp4 = ((c - 1) / 3) % 16;
      checks++;
      assert (bus4.retired === 4'(exp4)) else begin
        errors++;
        $error("FAIL retired_wrap cycle %0d: observed %0d expected %0d", c, bus4.retired, exp4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
